// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin burst arbiter in front of a shared 4:1 data mux. A grant is
//   held for a whole burst. It is released when the owner's last beat is
//   accepted. Priority then rotates so the last owner has lowest priority.
//   There is always one IDLE cycle between bursts.
//
//   Optional feature: define ARB_TIMEOUT_EN to add a stall counter. The
//   counter force-releases a grant after TIMEOUT_CYCLES consecutive BUSY
//   cycles with no accepted beat. A forced release pulses timeout_err for
//   one cycle.
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   req[3:0]         requester i presents a beat
//   last[3:0]        requester i's current beat ends its burst
//   din0..din3       requester data, DW bits
//   dn_ready         downstream accepts the presented beat
//   dn_valid         beat presented downstream
//   dout             din[sel], combinational
//   sel              registered index of the granted requester
//   gnt              registered one-hot grant, zero while idle
//   ack              one-hot accept strobe toward the granted requester
//   busy             arbiter is in BUSY
//   timeout_err      one-cycle pulse on forced release (always 0 by default)
module mux4_rr_arbiter #(
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TW             = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [3:0]    last,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic          dn_ready,
  output logic          dn_valid,
  output logic [DW-1:0] dout,
  output logic [1:0]    sel,
  output logic [3:0]    gnt,
  output logic [3:0]    ack,
  output logic          busy,
  output logic          timeout_err
);

  if (TIMEOUT_CYCLES < 2 || (64'd1 << TW) <= 64'(TIMEOUT_CYCLES)) begin : g_param_chk
    $error("mux4_rr_arbiter: need TIMEOUT_CYCLES >= 2 and 2**TW > TIMEOUT_CYCLES");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic       accept;
  logic       timeout_hit;

  // First set request scanning ptr+1, ptr+2, ptr+3, ptr. The loop runs from
  // lowest to highest priority, so the last hit is the winner.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    rr_pick = p;
    for (int k = 4; k >= 1; k--) begin
      idx = p + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign busy = (state_q == BUSY);
  assign sel  = sel_q;
  assign gnt  = gnt_q;

  always_comb begin
    case (sel_q)
      2'd0:    dout = din0;
      2'd1:    dout = din1;
      2'd2:    dout = din2;
      default: dout = din3;
    endcase
  end

  // rst gates the handshake so a burst interrupted by reset never acks.
  assign dn_valid = busy & req[sel_q] & ~rst;
  assign accept   = dn_valid & dn_ready;
  assign ack      = accept ? (4'b0001 << sel_q) : 4'b0000;

`ifdef ARB_TIMEOUT_EN
  logic [TW-1:0] stall_q, stall_d;
  logic          timeout_err_q, timeout_err_d;

  // The count reaches TIMEOUT_CYCLES on this cycle. A beat accepted in the
  // same cycle takes precedence.
  assign timeout_hit = busy & ~accept & (stall_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    stall_d       = '0;
    timeout_err_d = timeout_hit;
    if (busy && !accept && !timeout_hit) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      stall_q       <= stall_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = BUSY;
          sel_d   = rr_pick(req, ptr_q);
          gnt_d   = 4'b0001 << rr_pick(req, ptr_q);
        end
      end
      default: begin
        if ((accept && last[sel_q]) || timeout_hit) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = sel_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd3;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int DW = 32;
  localparam int TO = 6;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    req = '0;
  logic [3:0]    last = '0;
  logic [DW-1:0] din0 = '0, din1 = '0, din2 = '0, din3 = '0;
  logic          dn_ready = 1'b0;
  logic          dn_valid;
  logic [DW-1:0] dout;
  logic [1:0]    sel;
  logic [3:0]    gnt;
  logic [3:0]    ack;
  logic          busy;
  logic          timeout_err;

  mux4_rr_arbiter #(.DW(DW), .TIMEOUT_CYCLES(TO), .TW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .dn_ready(dn_ready), .dn_valid(dn_valid), .dout(dout), .sel(sel),
    .gnt(gnt), .ack(ack), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference model: who owns the port, whose turn follows, stall length.
  bit m_busy  = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 3;
  int m_stall = 0;
  bit m_terr  = 1'b0;
  logic [DW-1:0] din_a [4];

  // Outputs observed in the most recent step.
  logic [3:0] o_gnt, o_ack;
  logic [1:0] o_sel;
  logic       o_busy, o_dnv, o_terr;

  typedef struct {
    logic       rst;
    logic [3:0] req, last;
    logic       rdy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy, dnv;
    logic [3:0] ack;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] ls, input logic rdy,
                     input logic [3:0] g, input logic [1:0] s, input logic b, input logic v,
                     input logic [3:0] a);
    vec_t e;
    e.rst = r; e.req = rq; e.last = ls; e.rdy = rdy;
    e.gnt = g; e.sel = s; e.busy = b; e.dnv = v; e.ack = a;
    tbl.push_back(e);
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] ls, input logic rdy);
    logic       e_dnv;
    logic [3:0] e_ack;
    bit         acc;
    @(negedge clk);
    rst = r; req = rq; last = ls; dn_ready = rdy;
    for (int i = 0; i < 4; i++) din_a[i] = $urandom;
    din0 = din_a[0]; din1 = din_a[1]; din2 = din_a[2]; din3 = din_a[3];
    #1;
    o_gnt = gnt; o_sel = sel; o_busy = busy; o_dnv = dn_valid; o_ack = ack; o_terr = timeout_err;
    e_dnv = (!r && m_busy) ? rq[m_sel] : 1'b0;
    e_ack = (e_dnv && rdy) ? (4'(1) << m_sel) : 4'b0000;
    if (chk_en) begin
      chk("gnt", 64'(gnt), m_busy ? 64'(1 << m_sel) : 64'd0);
      chk("sel", 64'(sel), 64'(m_sel));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("dn_valid", 64'(dn_valid), 64'(e_dnv));
      chk("ack", 64'(ack), 64'(e_ack));
      chk("dout", 64'(dout), 64'(din_a[m_sel]));
      chk("timeout_err", 64'(timeout_err), 64'(m_terr));
    end
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_sel = 0; m_ptr = 3; m_stall = 0; m_terr = 0;
    end else begin
      m_terr = 0;
      if (!m_busy) begin
        for (int k = 1; k <= 4; k++) begin
          if (rq[(m_ptr + k) % 4]) begin
            m_sel = (m_ptr + k) % 4; m_busy = 1; m_stall = 0;
            break;
          end
        end
      end else begin
        acc = rq[m_sel] && rdy;
        if (acc && ls[m_sel]) begin
          m_busy = 0; m_ptr = m_sel; m_stall = 0;
        end else if (acc) begin
          m_stall = 0;
        end else begin
          m_stall++;
          if (TO_EN && m_stall >= TO) begin
            m_busy = 0; m_ptr = m_sel; m_terr = 1; m_stall = 0;
          end
        end
      end
    end
  endtask

  initial begin
    // Directed vectors: inputs applied in the cycle, outputs seen in that same cycle.
    add(1, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    // single 3-beat burst on requester 2
    add(0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 1, 4'b0100);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 1, 4'b0100);
    add(0, 4'b0100, 4'b0100, 1, 4'b0100, 2, 1, 1, 4'b0100);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 2, 0, 0, 4'b0000);
    // all requesting, single-beat bursts: 3,0,1,2 with an idle cycle between
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 2, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b1000, 3, 1, 1, 4'b1000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 3, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0001, 0, 1, 1, 4'b0001);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1, 1, 4'b0010);
    add(0, 4'b1111, 4'b1111, 1, 4'b0000, 1, 0, 0, 4'b0000);
    add(0, 4'b1111, 4'b1111, 1, 4'b0100, 2, 1, 1, 4'b0100);
    // requester 1 burst, 5 cycles of backpressure, then 3 wins over 0
    add(0, 4'b0010, 4'b0000, 1, 4'b0000, 2, 0, 0, 4'b0000);
    add(0, 4'b0010, 4'b0000, 1, 4'b0010, 1, 1, 1, 4'b0010);
    for (int i = 0; i < 5; i++)
      add(0, 4'b1011, 4'b0000, 0, 4'b0010, 1, 1, 1, 4'b0000);
    add(0, 4'b1011, 4'b0010, 1, 4'b0010, 1, 1, 1, 4'b0010);
    add(0, 4'b1011, 4'b1011, 1, 4'b0000, 1, 0, 0, 4'b0000);
    add(0, 4'b1011, 4'b1011, 1, 4'b1000, 3, 1, 1, 4'b1000);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 3, 0, 0, 4'b0000);
    // owner drops req mid-burst: valid falls, grant held
    add(0, 4'b0001, 4'b0000, 1, 4'b0000, 3, 0, 0, 4'b0000);
    add(0, 4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 1, 4'b0001);
    add(0, 4'b0000, 4'b0000, 1, 4'b0001, 0, 1, 0, 4'b0000);
    add(0, 4'b0001, 4'b0001, 1, 4'b0001, 0, 1, 1, 4'b0001);
    add(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    // reset during beat 2 of requester 2, then regrant from ptr=3
    add(0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 1, 4'b0100);
    add(1, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 0, 4'b0000);
    add(0, 4'b0100, 4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    add(0, 4'b0100, 4'b0000, 1, 4'b0100, 2, 1, 1, 4'b0100);
    add(0, 4'b0100, 4'b0100, 1, 4'b0100, 2, 1, 1, 4'b0100);

    step(1, 4'b0000, 4'b0000, 0);
    step(1, 4'b0000, 4'b0000, 0);
    chk_en = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].last, tbl[i].rdy);
      chk($sformatf("vec%0d.gnt", i), 64'(o_gnt), 64'(tbl[i].gnt));
      chk($sformatf("vec%0d.sel", i), 64'(o_sel), 64'(tbl[i].sel));
      chk($sformatf("vec%0d.busy", i), 64'(o_busy), 64'(tbl[i].busy));
      chk($sformatf("vec%0d.dn_valid", i), 64'(o_dnv), 64'(tbl[i].dnv));
      chk($sformatf("vec%0d.ack", i), 64'(o_ack), 64'(tbl[i].ack));
    end

`ifdef ARB_TIMEOUT_EN
    // Requester 0 granted and stalled; forced release, then requester 1 wins.
    step(0, 4'b0011, 4'b0000, 0);
    for (int i = 0; i < TO; i++) begin
      step(0, 4'b0011, 4'b0000, 0);
      chk("to.hold_gnt", 64'(o_gnt), 64'b0001);
      chk("to.no_err", 64'(o_terr), 64'd0);
    end
    step(0, 4'b0011, 4'b0000, 0);
    chk("to.err_pulse", 64'(o_terr), 64'd1);
    chk("to.gnt_released", 64'(o_gnt), 64'd0);
    step(0, 4'b0010, 4'b0010, 1);
    chk("to.err_cleared", 64'(o_terr), 64'd0);
    chk("to.next_gnt", 64'(o_gnt), 64'b0010);
    step(0, 4'b0000, 4'b0000, 1);
`endif

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) == 0), 4'($urandom), 4'($urandom & $urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
